inv: RTL and testbench

INV -- requirements
Module: inv

---
 rtl/inv_pkg.sv | 18 +
 rtl/inv_stage.sv | 41 ++++
 rtl/inv.sv | 56 +++++
 tb/tb_inv.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/inv_pkg.sv
// Shared defaults for the inv block: default width/depth and the all-ones mask generator.
package inv_pkg;

  localparam int DEFAULT_WIDTH  = 1;
  localparam int DEFAULT_STAGES = 0;
  localparam int MAX_WIDTH      = 64;

  // Lower `width` bits set; callers narrow the result to their own width.
  function automatic logic [MAX_WIDTH-1:0] ones_mask(input int width);
    logic [MAX_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/inv_stage.sv
// One enabled pipeline register for inv: data plus valid, async active-low reset
// of the data to RST_VAL and of the valid to 0.
module inv_stage #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d_in,
  input  logic             vld_in,
  output logic [WIDTH-1:0] d_out,
  output logic             vld_out
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (en) begin
      data_d = d_in;
      vld_d  = vld_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RST_VAL;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign d_out   = data_q;
  assign vld_out = vld_q;

endmodule

// File: rtl/inv.sv
// Masked inverter (out = in ^ INV_MASK) with an optional enabled pipeline of
// STAGES registers; STAGES=0 is a pure wire path usable as a toggle-flop feedback.
module inv
  import inv_pkg::*;
#(
  parameter int               WIDTH    = DEFAULT_WIDTH,
  parameter int               STAGES   = DEFAULT_STAGES,
  parameter logic [WIDTH-1:0] INV_MASK = WIDTH'(ones_mask(WIDTH))
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  input  logic             vld_in,
  output logic [WIDTH-1:0] out,
  output logic             vld_out
);

  generate
    if (STAGES == 0) begin : g_comb
      assign out     = in ^ INV_MASK;
      assign vld_out = vld_in;

      // Clock, reset and enable are intentionally unused on the wire path.
      logic unused_ok;
      assign unused_ok = ^{clk, reset_n, en};
    end else begin : g_pipe
      logic [WIDTH-1:0] data_chain [STAGES+1];
      logic [STAGES:0]  vld_chain;

      // Inversion happens before the first register so reset (INV_MASK) reads
      // as the inverse of an all-zero input.
      assign data_chain[0] = in ^ INV_MASK;
      assign vld_chain[0]  = vld_in;

      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        inv_stage #(
          .WIDTH   (WIDTH),
          .RST_VAL (INV_MASK)
        ) u_stage (
          .clk     (clk),
          .reset_n (reset_n),
          .en      (en),
          .d_in    (data_chain[gi]),
          .vld_in  (vld_chain[gi]),
          .d_out   (data_chain[gi+1]),
          .vld_out (vld_chain[gi+1])
        );
      end

      assign out     = data_chain[STAGES];
      assign vld_out = vld_chain[STAGES];
    end
  endgenerate

endmodule

// File: tb/tb_inv.sv
// Self-checking bench for inv: wire path, 1/2/3-stage pipelines, enable hold,
// async reset, randomized run against a queue model, and a toggle-flop ripple counter.
module tb_inv;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // STAGES=0, WIDTH=1
  logic a_in, a_vin, a_out, a_vout;
  inv #(.WIDTH(1), .STAGES(0)) u_a (
    .clk(clk), .reset_n(rst_n), .en(1'b0), .in(a_in), .vld_in(a_vin),
    .out(a_out), .vld_out(a_vout));

  // STAGES=2, WIDTH=4, default mask
  logic [3:0] b_in, b_out;
  logic       b_vin, b_vout, b_en;
  inv #(.WIDTH(4), .STAGES(2)) u_b (
    .clk(clk), .reset_n(rst_n), .en(b_en), .in(b_in), .vld_in(b_vin),
    .out(b_out), .vld_out(b_vout));

  // STAGES=1, WIDTH=4, mask 0101
  logic [3:0] c_in, c_out;
  logic       c_vin, c_vout, c_en;
  inv #(.WIDTH(4), .STAGES(1), .INV_MASK(4'b0101)) u_c (
    .clk(clk), .reset_n(rst_n), .en(c_en), .in(c_in), .vld_in(c_vin),
    .out(c_out), .vld_out(c_vout));

  // STAGES=3, WIDTH=8, mask 3C -- randomized against the queue model
  localparam logic [7:0] D_MASK = 8'h3C;
  logic [7:0] d_in, d_out;
  logic       d_vin, d_vout, d_en;
  inv #(.WIDTH(8), .STAGES(3), .INV_MASK(D_MASK)) u_d (
    .clk(clk), .reset_n(rst_n), .en(d_en), .in(d_in), .vld_in(d_vin),
    .out(d_out), .vld_out(d_vout));

  // Ripple counter: each bit is a negedge D flop fed back through an STAGES=0 inv.
  logic       tclk, t_rst_n;
  logic [3:0] tq, tinv, tvld, tck;
  assign tck = {tq[2:0], tclk};
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_tff
      inv #(.WIDTH(1), .STAGES(0)) u_t (
        .clk(1'b0), .reset_n(1'b1), .en(1'b0), .in(tq[gi]), .vld_in(1'b0),
        .out(tinv[gi]), .vld_out(tvld[gi]));
      always @(negedge tck[gi] or negedge t_rst_n) begin
        if (!t_rst_n) tq[gi] <= 1'b0;
        else          tq[gi] <= tinv[gi];
      end
    end
  endgenerate

  typedef struct {
    logic [3:0] din;
    logic       vin;
    logic       en;
    logic [3:0] eout;
    logic       evld;
  } vec_t;

  typedef struct packed {
    logic [7:0] d;
    logic       v;
  } ent_t;

  vec_t tbl [8];
  ent_t hist [$];

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < 3; k++) hist.push_back('{d: 8'h00, v: 1'b0});
  endtask

  task automatic d_step_and_check(input string name);
    logic [7:0] din_s;
    logic       vin_s, en_s;
    din_s = d_in; vin_s = d_vin; en_s = d_en;
    tick();
    if (en_s) begin
      hist.push_back('{d: din_s, v: vin_s});
      void'(hist.pop_front());
    end
    check({name, "_data"}, {56'd0, d_out}, {56'd0, hist[0].d ^ D_MASK});
    check({name, "_vld"}, {63'd0, d_vout}, {63'd0, hist[0].v});
  endtask

  initial begin
    // Stage-2 table: reset, 2-cycle latency, 3-cycle enable hold, resume
    tbl[0] = '{din: 4'h3, vin: 1'b1, en: 1'b1, eout: 4'hF, evld: 1'b0};
    tbl[1] = '{din: 4'h5, vin: 1'b0, en: 1'b1, eout: 4'hC, evld: 1'b1};
    tbl[2] = '{din: 4'h9, vin: 1'b1, en: 1'b0, eout: 4'hC, evld: 1'b1};
    tbl[3] = '{din: 4'h9, vin: 1'b1, en: 1'b0, eout: 4'hC, evld: 1'b1};
    tbl[4] = '{din: 4'h9, vin: 1'b1, en: 1'b0, eout: 4'hC, evld: 1'b1};
    tbl[5] = '{din: 4'h9, vin: 1'b1, en: 1'b1, eout: 4'hA, evld: 1'b0};
    tbl[6] = '{din: 4'h0, vin: 1'b0, en: 1'b1, eout: 4'h6, evld: 1'b1};
    tbl[7] = '{din: 4'h0, vin: 1'b0, en: 1'b1, eout: 4'hF, evld: 1'b0};

    rst_n = 1'b0; t_rst_n = 1'b0; tclk = 1'b1;
    a_in = 1'b0; a_vin = 1'b0;
    b_in = '0; b_vin = 1'b0; b_en = 1'b0;
    c_in = '0; c_vin = 1'b0; c_en = 1'b0;
    d_in = '0; d_vin = 1'b0; d_en = 1'b0;
    #12;
    check("rst_b_out", {60'd0, b_out}, 64'hF);
    check("rst_b_vld", {63'd0, b_vout}, 64'd0);
    check("rst_c_out", {60'd0, c_out}, 64'h5);
    check("rst_d_out", {56'd0, d_out}, {56'd0, D_MASK});
    check("rst_d_vld", {63'd0, d_vout}, 64'd0);

    // Wire path: same-delta response, valid passes straight through
    a_in = 1'b0; a_vin = 1'b1; #1;
    check("comb_in0", {63'd0, a_out}, 64'd1);
    check("comb_vld1", {63'd0, a_vout}, 64'd1);
    a_in = 1'b1; a_vin = 1'b0; #1;
    check("comb_in1", {63'd0, a_out}, 64'd0);
    check("comb_vld0", {63'd0, a_vout}, 64'd0);
    a_in = 1'b0; #1;
    check("comb_in0b", {63'd0, a_out}, 64'd1);

    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 8; i++) begin
      b_in = tbl[i].din; b_vin = tbl[i].vin; b_en = tbl[i].en;
      tick();
      check($sformatf("tbl%0d_out", i), {60'd0, b_out}, {60'd0, tbl[i].eout});
      check($sformatf("tbl%0d_vld", i), {63'd0, b_vout}, {63'd0, tbl[i].evld});
    end

    // Custom mask, single stage
    check("mask_pre", {60'd0, c_out}, 64'h5);
    c_in = 4'hF; c_vin = 1'b1; c_en = 1'b1;
    tick();
    check("mask_out", {60'd0, c_out}, 64'hA);
    check("mask_vld", {63'd0, c_vout}, 64'd1);
    c_en = 1'b0;

    // Randomized run on the 3-stage instance
    for (int i = 0; i < 200; i++) begin
      d_in  = 8'($urandom);
      d_vin = 1'($urandom);
      d_en  = ($urandom_range(0, 3) != 0);
      d_step_and_check($sformatf("rnd%0d", i));
    end

    // Mid-stream async reset between edges with data in flight
    d_en = 1'b1; d_vin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_in = 8'(8'h40 + i);
      d_step_and_check($sformatf("fill%0d", i));
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out", {56'd0, d_out}, {56'd0, D_MASK});
    check("midrst_vld", {63'd0, d_vout}, 64'd0);
    #1 rst_n = 1'b1;
    model_reset();
    d_in = 8'h11; d_vin = 1'b1; d_en = 1'b1;
    d_step_and_check("post0");
    d_in = 8'h00; d_vin = 1'b0;
    d_step_and_check("post1");
    d_step_and_check("post2");
    check("post_lat3_out", {56'd0, d_out}, 64'h2D);
    check("post_lat3_vld", {63'd0, d_vout}, 64'd1);

    // Ripple counter
    #1;
    check("tff_rst", {60'd0, tq}, 64'd0);
    t_rst_n = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      tclk = 1'b0;
      #1;
      check($sformatf("tff_cnt%0d", i), {60'd0, tq}, 64'((i + 1) % 16));
      tclk = 1'b1;
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
